// File: rtl/cipher_pkg.sv
// Shared types and constants for the multi-channel Galois-LFSR stream cipher.
package cipher_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } cipher_state_e;

  // Stored wide so any LFSR width up to 64 can slice its defaults from them.
  localparam logic [63:0] DEF_TAPS_64 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] DEF_SEED_64 = 64'h0000_0000_0000_0055;

  // Length of the serial config chain: {taps, seed} for every channel.
  function automatic int cfg_len(input int n_ch, input int lfsr_w);
    return 2 * lfsr_w * n_ch;
  endfunction

endpackage

// File: rtl/multi_channel_stream_cipher_if.sv
// Config chain, per-channel stream signals and status of the stream cipher.
interface multi_channel_stream_cipher_if #(
  parameter int N_CH = 2
);
  // dout_vld[c] qualifies dout[c] for exactly one cycle; there is no ready,
  // so the consumer must take every valid bit in the cycle it appears.
  logic            cfg_en;
  logic            cfg_i;
  logic            cfg_o;
  logic            cfg_err;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] resync;
  logic [N_CH-1:0] din;
  logic [N_CH-1:0] dout;
  logic [N_CH-1:0] dout_vld;
  logic [2:0]      heartbeat;
  logic [1:0]      fsm_state;

  modport master (
    output cfg_en, cfg_i, ch_en, resync, din,
    input  cfg_o, cfg_err, dout, dout_vld, heartbeat, fsm_state
  );

  modport slave (
    input  cfg_en, cfg_i, ch_en, resync, din,
    output cfg_o, cfg_err, dout, dout_vld, heartbeat, fsm_state
  );

endinterface

// File: rtl/lfsr_keystream.sv
// One cipher channel: Galois LFSR state with load, resync and step, plus the
// registered XOR of the input bit with the current keystream bit.
module lfsr_keystream
  import cipher_pkg::*;
#(
  parameter int                LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] RST_SEED = {{(LFSR_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_seed,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  input  logic              ch_en,
  input  logic              resync,
  input  logic              din,
  output logic              dout,
  output logic              dout_vld
);

  logic [LFSR_W-1:0] state;
  logic              key;

  assign key = state[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_SEED;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      if (load) begin
        state <= load_seed;
      end else if (run) begin
        // resync wins over ch_en and produces no output bit
        if (resync) begin
          state <= seed;
        end else if (ch_en) begin
          dout     <= din ^ key;
          dout_vld <= 1'b1;
          state    <= (state >> 1) ^ (key ? taps : '0);
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_stream_cipher.sv
// N_CH independent Galois-LFSR stream cipher channels sharing one serial
// config chain that is committed atomically only when exactly CFG_LEN bits were shifted.
module multi_channel_stream_cipher
  import cipher_pkg::*;
#(
  parameter int                N_CH     = 2,
  parameter int                LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] DEF_TAPS = DEF_TAPS_64[LFSR_W-1:0],
  parameter logic [LFSR_W-1:0] DEF_SEED = DEF_SEED_64[LFSR_W-1:0]
) (
  input logic                         clk,
  input logic                         rst,
  multi_channel_stream_cipher_if.slave bus
);

  localparam int                CFG_LEN  = cfg_len(N_CH, LFSR_W);
  localparam int                CH_W     = 2 * LFSR_W;
  localparam int                CNT_W    = $clog2(CFG_LEN + 2);
  localparam logic [CNT_W-1:0]  LEN_C    = CNT_W'(CFG_LEN);
  localparam logic [CNT_W-1:0]  SAT_C    = CNT_W'(CFG_LEN + 1);
  localparam logic [LFSR_W-1:0] ONE      = {{(LFSR_W-1){1'b0}}, 1'b1};
  localparam logic [LFSR_W-1:0] RST_SEED = (DEF_SEED == '0) ? ONE : DEF_SEED;
  localparam logic [CFG_LEN-1:0] DEF_IMG = {N_CH{DEF_TAPS, DEF_SEED}};

  cipher_state_e                  st;
  logic [CNT_W-1:0]               bit_cnt;
  logic                           cfg_err_q;
  logic [15:0]                    hb_cnt;
  logic [CFG_LEN-1:0]             shadow;
  logic [CFG_LEN-1:0]             active_img;
  logic [N_CH-1:0][LFSR_W-1:0]    taps_act;
  logic [N_CH-1:0][LFSR_W-1:0]    seed_act;
  logic [N_CH-1:0][LFSR_W-1:0]    new_taps;
  logic [N_CH-1:0][LFSR_W-1:0]    new_seed;
  logic [N_CH-1:0]                dout_w;
  logic [N_CH-1:0]                vld_w;
  logic                           load_ok;
  logic                           run;

  always_comb begin
    active_img = '0;
    new_taps   = '0;
    new_seed   = '0;
    for (int c = 0; c < N_CH; c++) begin
      active_img[c*CH_W +: CH_W] = {taps_act[c], seed_act[c]};
      new_taps[c] = shadow[c*CH_W + LFSR_W +: LFSR_W];
      // an all-zero seed would lock the LFSR, so it is forced to 1
      new_seed[c] = (shadow[c*CH_W +: LFSR_W] == '0) ? ONE : shadow[c*CH_W +: LFSR_W];
    end
  end

  assign load_ok = (st == ST_LOAD) && (bit_cnt == LEN_C);
  assign run     = (st == ST_RUN) && !bus.cfg_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_RUN;
      bit_cnt   <= '0;
      cfg_err_q <= 1'b0;
      hb_cnt    <= '0;
      shadow    <= DEF_IMG;
      taps_act  <= {N_CH{DEF_TAPS}};
      seed_act  <= {N_CH{RST_SEED}};
    end else begin
      hb_cnt <= hb_cnt + 16'd1;
      case (st)
        ST_RUN: begin
          if (bus.cfg_en) begin
            st        <= ST_SHIFT;
            bit_cnt   <= '0;
            cfg_err_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          shadow <= {bus.cfg_i, shadow[CFG_LEN-1:1]};
          if (bit_cnt != SAT_C) bit_cnt <= bit_cnt + CNT_W'(1);
          if (!bus.cfg_en) st <= ST_LOAD;
        end
        ST_LOAD: begin
          st <= ST_RUN;
          if (load_ok) begin
            taps_act <= new_taps;
            seed_act <= new_seed;
          end else begin
            // wrong length: keep the live config and undo the partial shift
            cfg_err_q <= 1'b1;
            shadow    <= active_img;
          end
        end
        default: st <= ST_RUN;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lfsr_keystream #(
      .LFSR_W   (LFSR_W),
      .RST_SEED (RST_SEED)
    ) u_ks (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .load      (load_ok),
      .load_seed (new_seed[c]),
      .seed      (seed_act[c]),
      .taps      (taps_act[c]),
      .ch_en     (bus.ch_en[c]),
      .resync    (bus.resync[c]),
      .din       (bus.din[c]),
      .dout      (dout_w[c]),
      .dout_vld  (vld_w[c])
    );
  end

  assign bus.dout      = dout_w;
  assign bus.dout_vld  = vld_w;
  assign bus.cfg_o     = bus.cfg_en & shadow[0];
  assign bus.cfg_err   = cfg_err_q;
  assign bus.heartbeat = hb_cnt[9:7];
  assign bus.fsm_state = st;

endmodule

// File: tb/tb_multi_channel_stream_cipher.sv
// Directed bench for multi_channel_stream_cipher with hand-computed keystreams
// for the default taps 0x80200003 and seeds 0x55, 0x1 and 0x0.
module tb_multi_channel_stream_cipher;
  import cipher_pkg::*;

  localparam int N_CH    = 2;
  localparam int LFSR_W  = 32;
  localparam int CFG_LEN = cfg_len(N_CH, LFSR_W);

  logic clk;
  logic rst;
  logic [31:0] cyc;
  int n_checks;
  int n_errors;

  // k_i of the default seed 0x55: states 55, 80200029, C0300017, E0380008, ...
  logic [7:0] ks_def = 8'hC7;
  logic [1:0] exp_load[4]  = '{2'b01, 2'b01, 2'b11, 2'b00};
  logic [1:0] exp_bad[4]   = '{2'b00, 2'b10, 2'b01, 2'b01};
  logic [1:0] exp_zero[4]  = '{2'b11, 2'b11, 2'b10, 2'b01};

  multi_channel_stream_cipher_if #(.N_CH(N_CH)) bus ();

  multi_channel_stream_cipher #(
    .N_CH   (N_CH),
    .LFSR_W (LFSR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shifts nbits of img LSB-first; the last bit goes in with cfg_en low.
  task automatic shift_cfg(input logic [CFG_LEN-1:0] img, input int nbits, input logic [1:0] en_during);
    bus.ch_en  = '0;
    bus.resync = '0;
    bus.cfg_en = 1'b1;
    tick();
    check("shift_entry_state", 64'(bus.fsm_state), 64'(ST_SHIFT));
    check("shift_entry_err", 64'(bus.cfg_err), 64'd0);
    bus.ch_en = en_during;
    for (int i = 0; i < nbits; i++) begin
      bus.cfg_i  = img[i];
      bus.cfg_en = (i != nbits - 1);
      tick();
    end
    check("shift_frozen_vld", 64'(bus.dout_vld), 64'd0);
    check("shift_load_state", 64'(bus.fsm_state), 64'(ST_LOAD));
    bus.ch_en = '0;
    tick();
    check("shift_done_state", 64'(bus.fsm_state), 64'(ST_RUN));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.cfg_en = 1'b0;
    bus.cfg_i  = 1'b0;
    bus.ch_en  = '0;
    bus.resync = '0;
    bus.din    = '0;
    tick();
    tick();
    check("rst_state", 64'(bus.fsm_state), 64'(ST_RUN));
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_vld", 64'(bus.dout_vld), 64'd0);
    check("rst_err", 64'(bus.cfg_err), 64'd0);
    check("rst_cfg_o", 64'(bus.cfg_o), 64'd0);
    check("rst_heartbeat", 64'(bus.heartbeat), 64'd0);

    // default keystream on both channels, ch1 fed ones
    rst       = 1'b0;
    bus.ch_en = 2'b11;
    bus.din   = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("def_dout", 64'(bus.dout), 64'({~ks_def[i], ks_def[i]}));
      check("def_vld", 64'(bus.dout_vld), 64'd3);
    end

    // resync with ch_en: no output that cycle, then the sequence restarts
    bus.ch_en = 2'b01;
    bus.din   = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    bus.resync = 2'b01;
    tick();
    check("resync_vld", 64'(bus.dout_vld), 64'd0);
    check("resync_dout", 64'(bus.dout), 64'd0);
    bus.resync = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("resync_dout_seq", 64'(bus.dout), 64'({1'b0, ks_def[i]}));
      check("resync_vld_seq", 64'(bus.dout_vld), 64'd1);
    end

    // full-length load: ch1 seed 1, ch0 defaults; every channel restarts
    shift_cfg({32'h80200003, 32'h00000001, 32'h80200003, 32'h00000055}, CFG_LEN, 2'b11);
    check("load_ok_err", 64'(bus.cfg_err), 64'd0);
    bus.ch_en = 2'b11;
    bus.din   = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("load_ok_dout", 64'(bus.dout), 64'(exp_load[i]));
      check("load_ok_vld", 64'(bus.dout_vld), 64'd3);
    end

    // one bit short: error flagged, keystream continues untouched
    shift_cfg({CFG_LEN{1'b1}}, CFG_LEN - 1, 2'b11);
    check("short_err", 64'(bus.cfg_err), 64'd1);
    bus.ch_en = 2'b11;
    bus.din   = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("short_dout", 64'(bus.dout), 64'(exp_bad[i]));
    end

    // zero seed on ch0 becomes 1; entry check inside shift_cfg clears the error
    shift_cfg({32'h80200003, 32'h00000055, 32'h80200003, 32'h00000000}, CFG_LEN, 2'b00);
    check("zero_seed_err", 64'(bus.cfg_err), 64'd0);
    bus.ch_en = 2'b11;
    bus.din   = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_seed_dout", 64'(bus.dout), 64'(exp_zero[i]));
    end

    bus.ch_en = 2'b00;
    check("heartbeat", 64'(bus.heartbeat), 64'(cyc[9:7]));

    // reset in the middle of a long shift session
    bus.cfg_en = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      bus.cfg_i = 1'($urandom_range(0, 1));
      tick();
    end
    check("long_shift_state", 64'(bus.fsm_state), 64'(ST_SHIFT));
    rst = 1'b1;
    tick();
    check("midrst_state", 64'(bus.fsm_state), 64'(ST_RUN));
    check("midrst_dout", 64'(bus.dout), 64'd0);
    check("midrst_vld", 64'(bus.dout_vld), 64'd0);
    check("midrst_err", 64'(bus.cfg_err), 64'd0);
    check("midrst_heartbeat", 64'(bus.heartbeat), 64'd0);
    check("midrst_shadow_bit0", 64'(bus.cfg_o), 64'd1);
    rst        = 1'b0;
    bus.cfg_en = 1'b0;
    bus.ch_en  = 2'b01;
    bus.din    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_dout_seq", 64'(bus.dout), 64'({1'b0, ks_def[i]}));
      check("midrst_vld_seq", 64'(bus.dout_vld), 64'd1);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
